// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared memory bus, with a per-transaction
// watchdog that aborts accesses memory never answers.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_read,
  input  logic              p0_write,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_resp,
  output logic              p0_err,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_read,
  input  logic              p1_write,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_resp,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t        state;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] wd;

  logic req0, req1, grant;
  logic expire, done, abort;

  always_comb begin
    req0  = p0_read | p0_write;
    req1  = p1_read | p1_write;
    grant = (req0 && req1) ? ~last_grant : req1;
  end

  // mem_resp takes precedence over an expiring watchdog in the same cycle
  always_comb begin
    expire   = (state == BUSY) && (wd == WD_LAST);
    done     = (state == BUSY) && (mem_resp || expire) && !rst;
    abort    = done && !mem_resp;
    p0_resp  = done && !owner;
    p1_resp  = done && owner;
    p0_err   = abort && !owner;
    p1_err   = abort && owner;
    p0_rdata = (p0_resp && mem_resp) ? mem_rdata : '0;
    p1_rdata = (p1_resp && mem_resp) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      wd         <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner      <= grant;
            last_grant <= grant;
            wd         <= '0;
            state      <= BUSY;
            // write outranks read when a port raises both
            if (grant) begin
              mem_addr  <= p1_addr;
              mem_wdata <= p1_wdata;
              mem_write <= p1_write;
              mem_read  <= p1_read & ~p1_write;
            end else begin
              mem_addr  <= p0_addr;
              mem_wdata <= p0_wdata;
              mem_write <= p0_write;
              mem_read  <= p0_read & ~p0_write;
            end
          end
        end
        BUSY: begin
          if (mem_resp || expire) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DRAIN;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a driver plays requester and memory from a
// transaction-level model; a negedge monitor checks every response pulse.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] p0_addr, p1_addr, mem_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic          p0_read, p0_write, p0_resp, p0_err;
  logic          p1_read, p1_write, p1_resp, p1_err;
  logic          mem_read, mem_write, mem_resp;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_read(p0_read), .p0_write(p0_write),
    .p0_rdata(p0_rdata), .p0_resp(p0_resp), .p0_err(p0_err),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_read(p1_read), .p1_write(p1_write),
    .p1_rdata(p1_rdata), .p1_resp(p1_resp), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    bit            port;
    bit            err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;

  // Requester model: level requests per port plus round-robin history
  bit            last;
  bit            act[2];
  bit            rd[2];
  bit            wr[2];
  logic [AW-1:0] ad[2];
  logic [DW-1:0] wdat[2];

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    total++;
    if (act_v === exp_v) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
  endtask

  task automatic apply_ports();
    p0_addr = ad[0]; p0_wdata = wdat[0]; p0_read = act[0] & rd[0]; p0_write = act[0] & wr[0];
    p1_addr = ad[1]; p1_wdata = wdat[1]; p1_read = act[1] & rd[1]; p1_write = act[1] & wr[1];
  endtask

  task automatic new_req(input int p);
    int unsigned kind;
    kind    = $urandom_range(0, 2);
    act[p]  = 1'b1;
    rd[p]   = (kind != 1);
    wr[p]   = (kind != 0);
    ad[p]   = $urandom;
    wdat[p] = $urandom;
  endtask

  // Called at posedge+1 of an IDLE cycle with the request model already set.
  // lat = BUSY cycle (1-based) in which memory answers; beyond TO it never does.
  task automatic run_txn(input int lat, input bit spur, input bit fixd,
                         input logic [DW-1:0] fdata, output bit win);
    int            n;
    bit            w, terr;
    logic [DW-1:0] rv;
    exp_t          e;
    w    = (act[0] && act[1]) ? !last : act[1];
    last = w;
    win  = w;
    n    = (lat < TO) ? lat : TO;
    terr = (lat > TO);
    apply_ports();
    @(posedge clk); #1;
    chk("grant_addr",  mem_addr,  ad[w]);
    chk("grant_wdata", mem_wdata, wdat[w]);
    chk("grant_strobes", {mem_read, mem_write}, {rd[w] && !wr[w], wr[w]});
    for (int k = 1; k <= n; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
        chk("busy_addr", mem_addr, ad[w]);
        chk("busy_strobes", {mem_read, mem_write}, {rd[w] && !wr[w], wr[w]});
      end
      if (k == 2 && !act[!w] && $urandom_range(0, 1) == 1) begin
        new_req(!w);
        apply_ports();
      end
      rv        = (fixd && k == lat) ? fdata : DW'($urandom);
      mem_rdata = rv;
      mem_resp  = (k == lat);
      if (k == n) begin
        e.port  = w;
        e.err   = terr;
        e.rdata = terr ? '0 : rv;
        sbq.push_back(e);
      end
    end
    @(posedge clk); #1;
    mem_resp = spur && ($urandom_range(0, 1) == 1);
    act[w]   = 1'b0;
    apply_ports();
    chk("drain_strobes", {mem_read, mem_write}, 2'b00);
    @(posedge clk); #1;
    mem_resp = spur && ($urandom_range(0, 1) == 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (p0_resp || p1_resp) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL spurious_resp: p0_resp=%0b p1_resp=%0b expected no response", p0_resp, p1_resp);
      end else begin
        e = sbq.pop_front();
        chk("resp_port",  {p1_resp, p0_resp}, e.port ? 2'b10 : 2'b01);
        chk("resp_err",   e.port ? p1_err : p0_err, e.err);
        chk("resp_rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
        chk("other_rdata", e.port ? p0_rdata : p1_rdata, 0);
        chk("other_err",   e.port ? p0_err : p1_err, 0);
      end
    end
  end

  initial begin
    bit win;
    mem_resp = 1'b0;
    mem_rdata = '0;
    last = 1'b1;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; wdat[p] = '0;
    end
    apply_ports();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_addr",  mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_strobes",   {mem_read, mem_write}, 2'b00);
    chk("reset_resp",      {p0_resp, p1_resp, p0_err, p1_err}, 4'b0000);
    chk("reset_rdata",     {p0_rdata, p1_rdata}, 0);
    rst = 1'b0;

    // Both ports held: p0 write 0x200/0x11 against p1 read 0x300
    act[0] = 1; rd[0] = 0; wr[0] = 1; ad[0] = 32'h200; wdat[0] = 32'h11;
    act[1] = 1; rd[1] = 1; wr[1] = 0; ad[1] = 32'h300; wdat[1] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      run_txn($urandom_range(1, 6), 1'b0, 1'b0, '0, win);
      chk("rr_order", win, i % 2);
      act[win] = 1'b1;
    end

    // Single p0 read, memory answers 3 cycles after mem_read rises
    act[0] = 1; rd[0] = 1; wr[0] = 0; ad[0] = 32'h100;
    act[1] = 0;
    run_txn(4, 1'b0, 1'b1, 32'hDEADBEEF, win);

    // Watchdog abort, then p1 served normally
    act[0] = 1; rd[0] = 1; wr[0] = 0; ad[0] = 32'h400;
    run_txn(20, 1'b0, 1'b0, '0, win);
    act[1] = 1; rd[1] = 1; wr[1] = 0; ad[1] = 32'h500;
    run_txn(2, 1'b0, 1'b1, 32'h12345678, win);
    chk("after_timeout_grant", win, 1);

    // mem_resp on the watchdog's final cycle
    act[0] = 1; rd[0] = 1; wr[0] = 0; ad[0] = 32'h600;
    run_txn(TO, 1'b0, 1'b1, 32'hCAFEF00D, win);

    // Reset in the middle of BUSY
    new_req(0);
    new_req(1);
    apply_ports();
    mem_resp = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    act[0] = 0; act[1] = 0;
    apply_ports();
    @(posedge clk); #1;
    chk("mid_reset_strobes", {mem_read, mem_write}, 2'b00);
    rst  = 1'b0;
    last = 1'b1;
    new_req(0);
    new_req(1);
    run_txn($urandom_range(1, 5), 1'b1, 1'b0, '0, win);
    chk("post_reset_grant", win, 0);

    for (int i = 0; i < 150; i++) begin
      for (int p = 0; p < 2; p++)
        if (!act[p] && $urandom_range(0, 9) < 7) new_req(p);
      if (!act[0] && !act[1]) new_req(int'($urandom_range(0, 1)));
      run_txn($urandom_range(1, TO + 2), 1'b1, 1'b0, '0, win);
    end

    mem_resp = 1'b0;
    act[0] = 0; act[1] = 0;
    apply_ports();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port, round-robin arbiter that shares the core's single memory interface between port 0 (core_top memory port) and port 1 (DMA/debug loader). It registers the winning request onto the downstream memory bus and holds it until mem_resp. It routes the response back to the owner only. A per-transaction watchdog aborts accesses that memory never answers.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles a transaction waits for mem_resp before abort (1..65535)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
p0_addr  in  ADDR_W  port 0 address
p0_wdata  in  DATA_W  port 0 write data
p0_read  in  1  port 0 read request (level, held until p0_resp)
p0_write  in  1  port 0 write request (level, held until p0_resp)
p0_rdata  out  DATA_W  port 0 read data (valid with p0_resp)
p0_resp  out  1  port 0 completion pulse
p0_err  out  1  port 0 timeout flag (valid with p0_resp)
p1_addr, p1_wdata, p1_read, p1_write, p1_rdata, p1_resp, p1_err: same as port 0, for port 1
mem_addr  out  ADDR_W  downstream address (registered)
mem_wdata  out  DATA_W  downstream write data (registered)
mem_read  out  1  downstream read strobe (registered, level)
mem_write  out  1  downstream write strobe (registered, level)
mem_rdata  in  DATA_W  downstream read data
mem_resp  in  1  downstream completion

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset: FSM=IDLE, mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0, last_grant=1 (port 0 wins first tie), wd counter=0. All pN_resp/pN_err=0; pN_rdata=0.
- States: IDLE, BUSY, DRAIN.
- IDLE: if any port requests (read|write), grant per round-robin. Both requesting means the grant goes to !last_grant; otherwise the requester wins. On grant, in the same edge: latch owner, load mem_addr/mem_wdata from the owner, set mem_read/mem_write, clear wd counter, update last_grant, go BUSY. First mem strobe therefore appears 1 cycle after the request is seen.
- read and write both high on one port: write wins, read ignored.
- BUSY: strobes and address stay stable. Other port's requests are ignored (no preemption). wd counter increments each cycle.
- BUSY and mem_resp=1: pOwner_resp=1 combinationally in the same cycle. pOwner_rdata=mem_rdata (passthrough, owner only; non-owner rdata=0). pOwner_err=0. Next edge: strobes cleared, go DRAIN.
- DRAIN: 1-cycle turnaround, strobes low, then IDLE. Requester must drop its request in the cycle after resp; a request still high in DRAIN is not sampled until IDLE. Back-to-back same-port access costs resp + 2 cycles.
- Watchdog: in BUSY, if wd counter == TIMEOUT-1 and mem_resp=0, assert pOwner_resp=1 and pOwner_err=1 for that cycle with rdata=0. Next edge: strobes cleared, go DRAIN. If mem_resp and timeout coincide, mem_resp wins (err=0).
- Owner drops its request mid-BUSY: transaction continues to completion. resp/err are still pulsed and the requester must ignore them. No abort on withdrawal.
- mem_resp while in IDLE or DRAIN is ignored; no port sees resp.
- Reset mid-transaction: strobes drop on the reset edge, state returns to IDLE, and any in-flight resp is dropped.
- Counter width is ceil(log2(TIMEOUT+1)) bits. The counter saturates and never wraps.

Test Plan:
- Single read p0, addr=0x100, memory responds 3 cycles after mem_read rises with 0xDEADBEEF: mem_read/mem_addr=0x100 appear 1 cycle after p0_read. p0_resp pulses with p0_rdata=0xDEADBEEF. p1_resp stays 0. FSM is IDLE 2 cycles after resp.
- Simultaneous p0 write (0x200, 0x11) and p1 read (0x300) held continuously: grant order after reset is p0, p1, p0, p1. Each grant waits out DRAIN. mem_write is never high together with mem_read.
- Contention during BUSY: p1 raises a request while p0 is being served. p1's address never appears on mem_addr until p0 completes plus 2 cycles.
- Timeout with TIMEOUT=8, mem_resp held 0: p0_resp and p0_err assert together on the 8th BUSY cycle. Strobes drop the next cycle, and a subsequent p1 request is served normally.
- mem_resp and timeout in the same cycle: err=0, rdata passes through.
- Reset asserted in BUSY: strobes are 0 after the reset edge and no pN_resp is pulsed. The arbiter resumes with port 0 priority.
